// File: rtl/psum_readout_drain_pkg.sv
// Shared sizes and FSM encoding for the PSUM readout drain.
// Matches the ofifo/sfu defines used by the array top.
package psum_readout_drain_pkg;

  localparam int PSUM_BW     = 16;
  localparam int COL         = 8;
  localparam int O_NIJ       = 16;
  localparam int PMEM_RD_LAT = 2;

  localparam int DW    = PSUM_BW * COL;
  localparam int AW    = $clog2(O_NIJ);
  localparam int CNT_W = $clog2(O_NIJ + 1);
  localparam int LAT_W = $clog2(PMEM_RD_LAT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TRIG  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  typedef logic [COL-1:0][PSUM_BW-1:0] word_t;

endpackage

// File: rtl/psum_readout_drain_if.sv
// Control, SFU readout and drain handshake bundle for psum_readout_drain.
// slave = the drain block, master = controller / SFU / sink side.
interface psum_readout_drain_if;
  import psum_readout_drain_pkg::*;

  logic          start;
  logic          relu_en;
  logic          readout_start;
  logic [DW-1:0] readout;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;

  modport slave (
    input  start, relu_en, readout, out_ready,
    output readout_start, out_valid, out_data, out_addr, busy, done
  );

  modport master (
    output start, relu_en, readout, out_ready,
    input  readout_start, out_valid, out_data, out_addr, busy, done
  );

endinterface

// File: rtl/psum_readout_drain_fifo.sv
// Registered synchronous FIFO with async reset; head entry is read
// straight from the storage registers so data appears the cycle after a write.
module readout_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_wr, do_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  // Storage is cleared on reset so out_data reads zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_wr && !do_rd)      cnt_q <= cnt_q + 1'b1;
      else if (!do_wr && do_rd) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/psum_readout_drain.sv
// Triggers an SFU PSUM readout, captures the fixed-latency unstallable
// stream into a full-depth buffer and drains it (optionally ReLU'd) over valid/ready.
module psum_readout_drain
  import psum_readout_drain_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  psum_readout_drain_if.slave   bus
);

  state_e            state_q, state_d;
  logic              relu_q, relu_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [AW-1:0]     cap_q, cap_d;
  logic [AW-1:0]     drn_q, drn_d;
  logic              done_q, done_d;
  logic              rd_start, cap_en, hs;

  word_t             rd_w, relu_w;
  logic [DW-1:0]     fifo_rdata;
  logic              fifo_empty;
  logic              fifo_full_unused;
  logic [CNT_W-1:0]  fifo_cnt_unused;

  assign hs = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      relu_q  <= 1'b0;
      lat_q   <= '0;
      cap_q   <= '0;
      drn_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      relu_q  <= relu_d;
      lat_q   <= lat_d;
      cap_q   <= cap_d;
      drn_q   <= drn_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    relu_d   = relu_q;
    lat_d    = lat_q;
    cap_d    = cap_q;
    drn_d    = hs ? drn_q + 1'b1 : drn_q;
    done_d   = 1'b0;
    rd_start = 1'b0;
    cap_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_TRIG;
          relu_d  = bus.relu_en;
          drn_d   = '0;
          cap_d   = '0;
        end
      end
      ST_TRIG: begin
        rd_start = 1'b1;
        lat_d    = LAT_W'(PMEM_RD_LAT - 1);
        state_d  = (PMEM_RD_LAT > 1) ? ST_WAIT : ST_CAPT;
      end
      // Counter reaches zero on the last WAIT cycle, so the first word
      // lands exactly PMEM_RD_LAT cycles after the trigger.
      ST_WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q <= LAT_W'(1)) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        cap_en = 1'b1;
        cap_d  = cap_q + 1'b1;
        if (cap_q == AW'(O_NIJ - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (hs && drn_q == AW'(O_NIJ - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // relu_q is frozen for the whole readout, so clamping on the write side
  // is equivalent to clamping on drain.
  assign rd_w = bus.readout;
  for (genvar l = 0; l < COL; l++) begin : g_relu
    assign relu_w[l] = (relu_q && rd_w[l][PSUM_BW-1]) ? '0 : rd_w[l];
  end

  readout_fifo #(
    .DEPTH (O_NIJ),
    .WIDTH (DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .wr_en_i (cap_en),
    .wdata_i (relu_w),
    .rd_en_i (bus.out_ready),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full_unused),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt_unused)
  );

  assign bus.readout_start = rd_start;
  assign bus.out_valid     = !fifo_empty;
  assign bus.out_data      = fifo_rdata;
  assign bus.out_addr      = drn_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.done          = done_q;

endmodule

// File: tb/tb_psum_readout_drain.sv
// Directed bench for psum_readout_drain: an SFU stream model, an expected
// output queue built from the ReLU rule, and a per-cycle output checker.
module tb_psum_readout_drain;
  import psum_readout_drain_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  psum_readout_drain_if bus();

  psum_readout_drain dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]    addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, sfu_t = -1, cur_pat = 0;
  int rs_cnt = 0, done_cnt = 0, hs_cnt = 0;

  function automatic logic [15:0] lane_val(input int pat, input int k, input int j);
    case (pat)
      0:       return 16'(k * 8 + j);
      1:       return (j % 2 == 0) ? 16'hFFFB : 16'd7;
      2:       return 16'(32'h8000 + k * 16 + j);
      default: return (j % 3 == 0) ? 16'(-(k * 8 + j + 1)) : 16'(k * 8 + j);
    endcase
  endfunction

  function automatic logic [DW-1:0] word(input int pat, input int k, input bit relu);
    logic [DW-1:0] w;
    logic [15:0]   v;
    w = '0;
    for (int j = 0; j < COL; j++) begin
      v = lane_val(pat, k, j);
      if (relu && v[15]) v = '0;
      w[j*16 +: 16] = v;
    end
    return w;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // SFU: word k sits on readout during the (rd_lat+k)-th cycle after readout_start.
  always @(negedge clk) begin
    if (bus.readout_start) sfu_t = 0;
    else if (sfu_t >= 0 && sfu_t < 40) sfu_t++;
    if (sfu_t >= PMEM_RD_LAT && sfu_t < PMEM_RD_LAT + O_NIJ)
      bus.readout = word(cur_pat, sfu_t - PMEM_RD_LAT, 1'b0);
    else
      bus.readout = '0;
  end

  // Output checker against the expected queue.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (bus.readout_start) begin
        rs_cnt++;
        chk("rs_cycle", cyc, start_cyc + 1);
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("extra_output", 1, 0);
        else begin
          chk("out_addr", int'(bus.out_addr), int'(exp_q[0].addr));
          chk_w("out_data", bus.out_data, exp_q[0].data);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_pending_words", exp_q.size(), 0);
        chk("busy_at_done", int'(bus.busy), 0);
      end
    end
  end

  task automatic start_run(input int pat, input bit relu);
    cur_pat = pat;
    for (int k = 0; k < O_NIJ; k++) exp_q.push_back('{addr: 4'(k), data: word(pat, k, relu)});
    rs_cnt = 0; done_cnt = 0; hs_cnt = 0;
    bus.relu_en = relu;
    bus.start   = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.relu_en = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk); #2;
      seen = bus.out_valid;
    end
    if (!seen) chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_done(input int max, input bit rnd);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      #2;
      seen = bus.done;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic post_run();
    chk("rs_pulses", rs_cnt, 1);
    chk("done_pulses", done_cnt, 1);
    chk("handshakes", hs_cnt, O_NIJ);
    chk("busy_after", int'(bus.busy), 0);
    chk("words_left", exp_q.size(), 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.relu_en = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_readout_start", int'(bus.readout_start), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk_w("rst_out_data", bus.out_data, '0);
    chk("rst_out_addr", int'(bus.out_addr), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic pass-through, free-flowing sink
    start_run(0, 1'b0);
    wait_valid(10);
    chk("basic_first_valid_cyc", cyc, start_cyc + 4);
    chk("basic_first_addr", int'(bus.out_addr), 0);
    chk("basic_w0_lane1", int'(bus.out_data[16 +: 16]), 1);
    wait_done(60, 1'b0);
    post_run();

    // ReLU on, then off back-to-back with start issued in the done cycle
    @(negedge clk);
    start_run(1, 1'b1);
    wait_valid(10);
    chk("relu_lane0", int'(bus.out_data[0 +: 16]), 0);
    chk("relu_lane1", int'(bus.out_data[16 +: 16]), 7);
    wait_done(60, 1'b0);
    post_run();
    start_run(1, 1'b0);
    wait_valid(10);
    chk("norelu_lane0", int'(bus.out_data[0 +: 16]), 32'hFFFB);
    chk("norelu_lane1", int'(bus.out_data[16 +: 16]), 7);
    wait_done(60, 1'b0);
    post_run();

    // Full backpressure until T+40
    @(negedge clk);
    bus.out_ready = 1'b0;
    start_run(2, 1'b0);
    wait_valid(10);
    chk("bp_first_valid_cyc", cyc, start_cyc + 4);
    while (cyc < start_cyc + 40) @(negedge clk);
    chk("bp_valid_held", int'(bus.out_valid), 1);
    chk("bp_addr_held", int'(bus.out_addr), 0);
    chk("bp_w0_lane0", int'(bus.out_data[0 +: 16]), 32'h8000);
    bus.out_ready = 1'b1;
    wait_done(60, 1'b0);
    post_run();

    // Random sink readiness overlapping capture
    @(negedge clk);
    start_run(3, 1'b1);
    wait_done(300, 1'b1);
    post_run();
    bus.out_ready = 1'b1;

    // Second start during capture must be ignored
    @(negedge clk);
    start_run(0, 1'b0);
    while (cyc < start_cyc + 6) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(60, 1'b0);
    post_run();

    // Reset mid-capture, after word 6 has been captured
    @(negedge clk);
    start_run(2, 1'b0);
    while (cyc < start_cyc + 10) @(negedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk_w("midrst_out_data", bus.out_data, '0);
    chk("midrst_out_addr", int'(bus.out_addr), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_readout_start", int'(bus.readout_start), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    chk("midrst_trailing_ignored", int'(bus.out_valid), 0);
    chk("midrst_idle", int'(bus.busy), 0);

    // Clean readout after reset
    @(negedge clk);
    start_run(0, 1'b0);
    wait_valid(10);
    chk("post_rst_first_addr", int'(bus.out_addr), 0);
    wait_done(60, 1'b0);
    post_run();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
